// File: rtl/param_regfile_if.sv
// rtl/param_regfile_if.sv - write/read port bundle for param_regfile
interface param_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeData;
    logic              readEnable1;
    logic [ADDR_W-1:0] readAddress1;
    logic              readEnable2;
    logic [ADDR_W-1:0] readAddress2;
    logic [DATA_W-1:0] readData1;
    logic              readValid1;
    logic [DATA_W-1:0] readData2;
    logic              readValid2;
    logic              busy;
    logic              writeIgnored;

    modport master (
        output writeEnable, writeAddress, writeData,
        output readEnable1, readAddress1, readEnable2, readAddress2,
        input  readData1, readValid1, readData2, readValid2, busy, writeIgnored
    );

    modport slave (
        input  writeEnable, writeAddress, writeData,
        input  readEnable1, readAddress1, readEnable2, readAddress2,
        output readData1, readValid1, readData2, readValid2, busy, writeIgnored
    );
endinterface

// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - 1W/2R register file with registered reads and post-reset clear sweep
// REGFILE_BYPASS_EN selects write-first forwarding on same-address read/write; default is read-first.
module param_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    param_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_write;
    logic              do_read1, do_read2;
    logic [DATA_W-1:0] rd1, rd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        do_read1 = 1'b0;
        do_read2 = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_ptr == {ADDR_W{1'b1}}) state_d = READY;
            end
            READY: begin
                do_write = bus.writeEnable;
                do_read1 = bus.readEnable1;
                do_read2 = bus.readEnable2;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Forwarding only matters when a write lands on the address being read this cycle.
`ifdef REGFILE_BYPASS_EN
    assign rd1 = (do_write && bus.writeAddress == bus.readAddress1) ? bus.writeData : mem[bus.readAddress1];
    assign rd2 = (do_write && bus.writeAddress == bus.readAddress2) ? bus.writeData : mem[bus.readAddress2];
`else
    assign rd1 = mem[bus.readAddress1];
    assign rd2 = mem[bus.readAddress2];
`endif

    // Storage has no reset of its own; the sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (do_write) begin
                mem[bus.writeAddress] <= bus.writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr          <= '0;
            bus.readData1    <= '0;
            bus.readData2    <= '0;
            bus.readValid1   <= 1'b0;
            bus.readValid2   <= 1'b0;
            bus.writeIgnored <= 1'b0;
        end else begin
            if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            bus.writeIgnored <= (state_q == CLEAR) && bus.writeEnable;
            bus.readValid1   <= do_read1;
            bus.readValid2   <= do_read2;
            if (do_read1) bus.readData1 <= rd1;
            if (do_read2) bus.readData2 <= rd2;
        end
    end

    assign bus.busy = (state_q == CLEAR);
endmodule

// File: tb/tb_param_regfile.sv
// tb/tb_param_regfile.sv - directed self-checking bench for param_regfile
module tb_param_regfile;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [7:0] BYP_EXP = 8'h3C;
`else
    localparam logic [7:0] BYP_EXP = 8'h11;
`endif

    param_regfile_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    param_regfile #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic idle();
        bus.writeEnable  = 1'b0;
        bus.writeAddress = '0;
        bus.writeData    = '0;
        bus.readEnable1  = 1'b0;
        bus.readAddress1 = '0;
        bus.readEnable2  = 1'b0;
        bus.readAddress2 = '0;
    endtask

    initial begin
        int n;
        idle();
        #1;

        // Reset state and first clear sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_busy", bus.busy, 1);
        check_eq("rst_valid1", bus.readValid1, 0);
        check_eq("rst_valid2", bus.readValid2, 0);
        check_eq("rst_data1", bus.readData1, 0);
        check_eq("rst_data2", bus.readData2, 0);
        check_eq("rst_wign", bus.writeIgnored, 0);
        wait_ready(n);
        check_eq("sweep_len", n, 16);

        for (int a = 0; a < 16; a++) begin
            bus.readEnable1  = 1'b1;
            bus.readAddress1 = 4'(a);
            bus.readEnable2  = 1'b1;
            bus.readAddress2 = 4'(15 - a);
            tick();
            check_eq("zero_d1", bus.readData1, 0);
            check_eq("zero_v1", bus.readValid1, 1);
            check_eq("zero_d2", bus.readData2, 0);
            check_eq("zero_v2", bus.readValid2, 1);
        end
        idle();

        // Write then dual read of the same address
        bus.writeEnable  = 1'b1;
        bus.writeAddress = 4'd3;
        bus.writeData    = 8'hA5;
        tick();
        check_eq("wr_wign", bus.writeIgnored, 0);
        idle();
        bus.readEnable1  = 1'b1;
        bus.readAddress1 = 4'd3;
        bus.readEnable2  = 1'b1;
        bus.readAddress2 = 4'd3;
        tick();
        check_eq("dual_d1", bus.readData1, 8'hA5);
        check_eq("dual_v1", bus.readValid1, 1);
        check_eq("dual_d2", bus.readData2, 8'hA5);
        check_eq("dual_v2", bus.readValid2, 1);

        // Read enable dropped: valid falls, data holds
        idle();
        tick();
        check_eq("hold_v1", bus.readValid1, 0);
        check_eq("hold_d1", bus.readData1, 8'hA5);

        // Same-cycle write and read of addr 7
        bus.writeEnable  = 1'b1;
        bus.writeAddress = 4'd7;
        bus.writeData    = 8'h11;
        tick();
        bus.writeData    = 8'h3C;
        bus.readEnable1  = 1'b1;
        bus.readAddress1 = 4'd7;
        tick();
        check_eq("byp_d1", bus.readData1, BYP_EXP);
        check_eq("byp_v1", bus.readValid1, 1);
        bus.writeEnable = 1'b0;
        tick();
        check_eq("after_byp_d1", bus.readData1, 8'h3C);

        // Reset in READY wipes contents
        idle();
        bus.writeEnable  = 1'b1;
        bus.writeAddress = 4'd15;
        bus.writeData    = 8'h55;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst2_busy", bus.busy, 1);
        check_eq("rst2_data1", bus.readData1, 0);
        wait_ready(n);
        check_eq("sweep2_len", n, 16);
        bus.readEnable1  = 1'b1;
        bus.readAddress1 = 4'd15;
        tick();
        check_eq("wiped_d1", bus.readData1, 0);
        check_eq("wiped_v1", bus.readValid1, 1);

        // Reset mid-sweep restarts the full sweep
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("mid_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n);
        check_eq("sweep3_len", n, 16);

        // Write attempted on 5th sweep cycle is dropped; reads held during clear stay invalid
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.readEnable1  = 1'b1;
        bus.readAddress1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("clr_v1", bus.readValid1, 0);
        end
        bus.writeEnable  = 1'b1;
        bus.writeAddress = 4'd2;
        bus.writeData    = 8'hFF;
        tick();
        bus.writeEnable = 1'b0;
        check_eq("ign_pulse", bus.writeIgnored, 1);
        check_eq("ign_busy", bus.busy, 1);
        check_eq("ign_v1", bus.readValid1, 0);
        tick();
        check_eq("ign_end", bus.writeIgnored, 0);
        check_eq("ign_v1b", bus.readValid1, 0);
        bus.readEnable1 = 1'b0;
        wait_ready(n);
        check_eq("sweep4_rest", n, 10);
        bus.readEnable1  = 1'b1;
        bus.readAddress1 = 4'd2;
        tick();
        check_eq("ign_d1", bus.readData1, 0);
        check_eq("ign_rv1", bus.readValid1, 1);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
